// File: rtl/data_mem_wbuf_pkg.sv
// Shared definitions for the data-memory stage: bus width default, byte/word
// addressing constants, the posted-write FIFO entry layout and a clog2 helper.
package data_mem_wbuf_pkg;

    // Default data/address width of the core datapath.
    localparam int DEF_DATA_WIDTH = 32;

    // Word-aligned RAM: the low two address bits select a byte within a word.
    localparam int BYTE_OFF_BITS = 2;

    // Ceiling log2 usable in constant expressions (returns 0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // One posted write as it travels to the external bus.
    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/data_mem_wbuf_sync_fifo.sv
// Generic synchronous FIFO. A push into a full FIFO is accepted only when a pop
// happens in the same cycle, so a full FIFO can stream without losing entries.
// Occupancy is kept in its own counter so full and empty never alias.
module sync_fifo
    import data_mem_wbuf_pkg::*;
#(
    parameter int WIDTH = 2 * DEF_DATA_WIDTH,
    parameter int DEPTH = 4,
    localparam int PTR_W = clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = storage[rd_ptr];

    // Entry storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy moves only when exactly one of push/pop takes effect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_wbuf.sv
// Data-memory stage behind the single-cycle core. Loads come combinationally
// from a local word RAM; every store also goes out through a posted-write FIFO.
// The core cannot stall, so a store that finds the FIFO full keeps its RAM
// write but loses its bus copy, which is recorded in a sticky flag and a
// saturating counter.
module data_mem_wbuf
    import data_mem_wbuf_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 8,
    localparam int IDX_BITS  = clog2(MEM_WORDS),
    localparam int LVL_W     = clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  mem_write,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic [DATA_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_data,
    output logic [LVL_W-1:0]      fifo_level,
    output logic                  overflow,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    // The FIFO entry layout is fixed to the package width, so DATA_WIDTH is
    // expected to stay at its default.
    logic [DATA_WIDTH-1:0] ram [MEM_WORDS];
    logic [IDX_BITS-1:0]   ram_idx;
    fifo_entry_t           push_entry;
    fifo_entry_t           head_entry;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop_fire;
    logic                  drop;

    // Byte offset is ignored and higher address bits alias onto the RAM.
    assign ram_idx   = addr[IDX_BITS+BYTE_OFF_BITS-1:BYTE_OFF_BITS];
    assign read_data = ram[ram_idx];

    assign push_entry = '{addr: addr, data: wdata};
    assign bus_valid  = !fifo_empty;
    assign bus_addr   = head_entry.addr;
    assign bus_data   = head_entry.data;
    assign pop_fire   = bus_valid && bus_ready;
    assign drop       = mem_write && fifo_full && !pop_fire;

    // Stores always land in the RAM; a same-cycle load still sees the old word.
    always_ff @(posedge clk) begin
        if (mem_write) begin
            ram[ram_idx] <= wdata;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_wbuf (
        .clk     (clk),
        .reset   (reset),
        .push    (mem_write),
        .pop     (pop_fire),
        .wr_data (push_entry),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Record lost bus copies; the counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule
